// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: size encodings, FSM states and load helpers shared by the data memory LSU.
package dmem_lsu_pkg;
  localparam logic [2:0] LB_SB = 3'b000;
  localparam logic [2:0] LH_SH = 3'b001;
  localparam logic [2:0] LW_SW = 3'b010;
  localparam logic [2:0] LBU   = 3'b100;
  localparam logic [2:0] LHU   = 3'b101;
  typedef enum logic [2:0] {CLEAR, IDLE, WAIT, RESP, SPLIT} dmem_state_e;
  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [1:0]  sh;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] raw;
  } split_t;
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    return size == LW_SW ? 3'd4 : (size == LH_SH || size == LHU) ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [31:0] raw);
    return size == LW_SW ? raw :
           size == LHU   ? {16'h0, raw[15:0]} :
           size == LH_SH ? {{16{raw[15]}}, raw[15:0]} :
           size == LBU   ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
  endfunction
endpackage

// File: rtl/dmem_lsu_byte_array.sv
// dmem_byte_array: byte storage with a 4-lane byte-enable write port and a 4-byte combinational read port.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] wr_base,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_base,
  output logic [31:0]   rd_data
);
  logic [7:0] mem [DEPTH_BYTES];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_be[i]) mem[wr_base + AW'(i)] <= wr_data[8*i +: 8];
  end
  always_comb begin
    for (int i = 0; i < 4; i++) rd_data[8*i +: 8] = mem[rd_base + AW'(i)];
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: little-endian data memory with valid/ready channels, fault checks and post-reset clear.
// Defining DMEM_MISALIGN_SPLIT_EN performs in-range misaligned accesses as two beats instead of faulting.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1,
  parameter bit ZERO_RO     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              clr_busy
);
  localparam int AW = $clog2(DEPTH_BYTES);
  dmem_state_e state_q, state_d;
  logic [AW-3:0] clr_ptr_q, clr_ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic rsp_fault_q, rsp_fault_d, clr_busy_q, clr_busy_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] wr_base, rd_base;
  logic [3:0] wr_be, be_full, zmask, beat_mask;
  logic [31:0] wr_data, rd_data;
  logic [2:0] nbytes;
  logic [ADDR_W:0] end_addr;
  logic mis, oor, fault;
  assign nbytes = size_bytes(req_size);
  assign be_full = nbytes == 3'd4 ? 4'hF : nbytes == 3'd2 ? 4'h3 : 4'h1;
  assign zmask = ZERO_RO && req_addr == '0 ? 4'hE : 4'hF;
  assign mis = (nbytes == 3'd2 && req_addr[0]) || (nbytes == 3'd4 && req_addr[1:0] != 2'b00);
  assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);
  assign oor = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_SPLIT_EN
  split_t sp_q, sp_d;
  logic [AW-1:0] sp_addr_q, sp_addr_d;
  logic [1:0] sh;
  logic split;
  assign split = mis && !oor;
  assign fault = oor;
  // beat 1 runs up to the next word boundary; sh is the number of bytes it covers
  assign sh = 2'd0 - req_addr[1:0];
  assign beat_mask = split ? 4'hF >> req_addr[1:0] : 4'hF;
`else
  assign fault = mis || oor;
  assign beat_mask = 4'hF;
`endif
  always_comb begin
    state_d = state_q;
    clr_ptr_d = clr_ptr_q;
    cnt_d = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    clr_busy_d = clr_busy_q;
    wr_base = req_addr[AW-1:0];
    rd_base = req_addr[AW-1:0];
    wr_data = req_wdata;
    wr_be = 4'h0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    sp_d = sp_q;
    sp_addr_d = sp_addr_q;
`endif
    case (state_q)
      CLEAR: begin
        wr_base = {clr_ptr_q, 2'b00};
        wr_data = '0;
        wr_be = 4'hF;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) begin
          state_d = IDLE;
          clr_busy_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      IDLE: if (req_valid) begin
        req_ready_d = 1'b0;
        wr_be = req_we && !fault ? be_full & zmask & beat_mask : 4'h0;
        rsp_fault_d = fault;
        rsp_rdata_d = req_we || fault ? '0 : load_ext(req_size, rd_data);
        state_d = LATENCY > 1 ? WAIT : RESP;
        rsp_valid_d = LATENCY == 1;
        cnt_d = 4'(LATENCY - 1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        sp_d = '{we: req_we, size: req_size, sh: sh, be: be_full >> sh,
                 wdata: req_wdata >> {sh, 3'b000},
                 raw: rd_data & (32'hFFFF_FFFF >> {req_addr[1:0], 3'b000})};
        sp_addr_d = req_addr[AW-1:0] + AW'(sh);
        if (split) begin
          state_d = SPLIT;
          rsp_valid_d = 1'b0;
        end
`endif
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      SPLIT: begin
        wr_base = sp_addr_q;
        rd_base = sp_addr_q;
        wr_data = sp_q.wdata;
        wr_be = sp_q.we ? sp_q.be : 4'h0;
        rsp_rdata_d = sp_q.we ? '0 : load_ext(sp_q.size, sp_q.raw | (rd_data << {sp_q.sh, 3'b000}));
        state_d = LATENCY > 1 ? WAIT : RESP;
        rsp_valid_d = LATENCY == 1;
        cnt_d = 4'(LATENCY - 1);
      end
`endif
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      cnt_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      clr_busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      cnt_q <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      clr_busy_q <= clr_busy_d;
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    sp_q <= sp_d;
    sp_addr_q <= sp_addr_d;
`endif
  end
  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk     (clk),
    .wr_base (wr_base),
    .wr_be   (reset ? 4'h0 : wr_be),
    .wr_data (wr_data),
    .rd_base (rd_base),
    .rd_data (rd_data)
  );
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign clr_busy = clr_busy_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and randomized checks of dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;
  localparam int DEPTH = 1024;
  localparam int LAT = 3;
  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [2:0] req_size = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_fault, clr_busy;
  logic [31:0] rsp_rdata;
  logic [7:0] mdl [DEPTH];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  dmem_lsu #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(LAT), .ZERO_RO(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .clr_busy  (clr_busy)
  );
  // Reference: plain byte array, byte count from size, fault when not naturally aligned or past the end.
  task automatic model(input op_t op, output logic [31:0] rd, output logic flt, output int lat);
    int n;
    logic mis, oor;
    logic [31:0] v;
    n = op.sz == LW_SW ? 4 : (op.sz == LH_SH || op.sz == LHU) ? 2 : 1;
    mis = (op.a % n) != 0;
    oor = 64'(op.a) + 64'(n) > 64'(DEPTH);
`ifdef DMEM_MISALIGN_SPLIT_EN
    flt = oor;
    lat = (mis && !oor) ? LAT + 1 : LAT;
`else
    flt = mis || oor;
    lat = LAT;
`endif
    v = '0;
    rd = '0;
    if (!flt)
      for (int i = 0; i < n; i++) begin
        if (op.we) begin
          if (op.a + i != 0) mdl[op.a + i] = op.wd[8*i +: 8];
        end else v = v | (32'(mdl[op.a + i]) << (8 * i));
      end
    if (!flt && !op.we)
      case (op.sz)
        LW_SW, LBU, LHU: rd = v;
        LH_SH: rd = 32'($signed(v[15:0]));
        default: rd = 32'($signed(v[7:0]));
      endcase
  endtask
  task automatic run(input op_t op, output logic [31:0] rd, output logic flt, output int lat);
    int n = 0;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we = op.we;
    req_size = op.sz;
    req_addr = op.a;
    req_wdata = op.wd;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    flt = rsp_fault;
    @(negedge clk);
  endtask
  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
  endtask
  task automatic test_reset();
    int cyc = 0, bad = 0, lat, elat;
    logic [31:0] rd, erd;
    logic flt, eflt;
    op_t op;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({req_ready, rsp_valid, rsp_fault, clr_busy} !== 4'b0001 || rsp_rdata !== 32'h0)
      $display("FAIL reset_values: ready/valid/fault/busy=%b rdata=%h, expected 0001 rdata=0",
               {req_ready, rsp_valid, rsp_fault, clr_busy}, rsp_rdata);
    else passed++;
    while (clr_busy === 1'b1 && cyc < 5000) begin
      if (req_ready !== 1'b0) bad++;
      cyc++;
      @(negedge clk);
    end
    total++;
    if (cyc != DEPTH / 4) $display("FAIL clear_len: clr_busy high %0d cycles, expected %0d", cyc, DEPTH / 4);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL clear_ready: req_ready high in %0d clear cycles, expected 0", bad);
    else passed++;
    total++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_clear: req_ready=%b expected 1", req_ready);
    else passed++;
    clear_model();
    op = '{1'b0, LW_SW, 32'h10, 32'h0};
    model(op, erd, eflt, elat);
    run(op, rd, flt, lat);
    total++;
    if (rd !== erd || flt !== eflt || lat != elat)
      $display("FAIL clear_load: rdata=%h fault=%b lat=%0d, expected %h %b %0d", rd, flt, lat, erd, eflt, elat);
    else passed++;
  endtask
  task automatic test_directed(input string name, input op_t ops[$]);
    logic [31:0] rd, erd;
    logic flt, eflt;
    int lat, elat;
    foreach (ops[i]) begin
      model(ops[i], erd, eflt, elat);
      run(ops[i], rd, flt, lat);
      total++;
      if (rd !== erd) $display("FAIL %s_rdata op%0d: rdata=%h expected %h", name, i, rd, erd);
      else passed++;
      total++;
      if (flt !== eflt) $display("FAIL %s_fault op%0d: fault=%b expected %b", name, i, flt, eflt);
      else passed++;
      total++;
      if (lat != elat) $display("FAIL %s_latency op%0d: latency=%0d expected %0d", name, i, lat, elat);
      else passed++;
    end
  endtask
  task automatic test_byte_lanes();
    op_t ops[$];
    ops = '{'{1'b1, LW_SW, 32'h20, 32'h8899AABB}, '{1'b0, LB_SB, 32'h21, 32'h0},
            '{1'b0, LBU, 32'h21, 32'h0}, '{1'b0, LH_SH, 32'h22, 32'h0},
            '{1'b0, LHU, 32'h22, 32'h0}, '{1'b1, LBU, 32'h25, 32'hFFFF_FF7F},
            '{1'b0, LW_SW, 32'h24, 32'h0}, '{1'b1, LHU, 32'h26, 32'h1234_8001},
            '{1'b0, LH_SH, 32'h26, 32'h0}, '{1'b0, 3'b111, 32'h20, 32'h0}};
    test_directed("lanes", ops);
  endtask
  task automatic test_faults();
    op_t ops[$];
    ops = '{'{1'b0, LW_SW, 32'h22, 32'h0}, '{1'b1, LW_SW, 32'h3FE, 32'h11223344},
            '{1'b0, LHU, 32'h3FE, 32'h0}, '{1'b1, LB_SB, 32'h3FF, 32'h5A},
            '{1'b0, LBU, 32'h3FF, 32'h0}, '{1'b0, LB_SB, 32'h400, 32'h0},
            '{1'b1, LW_SW, 32'h8000_0010, 32'hFFFF_FFFF}, '{1'b0, LW_SW, 32'h10, 32'h0},
            '{1'b0, LW_SW, 32'h3FC, 32'h0}, '{1'b0, LH_SH, 32'h23, 32'h0}};
    test_directed("fault", ops);
  endtask
  task automatic test_zero_ro();
    op_t ops[$];
    ops = '{'{1'b1, LW_SW, 32'h0, 32'hDEADBEEF}, '{1'b0, LW_SW, 32'h0, 32'h0},
            '{1'b1, LB_SB, 32'h0, 32'h55}, '{1'b0, LBU, 32'h0, 32'h0},
            '{1'b1, LH_SH, 32'h0, 32'hA1B2}, '{1'b0, LH_SH, 32'h0, 32'h0}};
    test_directed("zero_ro", ops);
  endtask
  task automatic test_split();
    op_t ops[$];
    ops = '{'{1'b1, LW_SW, 32'h21, 32'h11223344}, '{1'b0, LW_SW, 32'h21, 32'h0},
            '{1'b1, LH_SH, 32'h27, 32'h0000CAFE}, '{1'b0, LHU, 32'h27, 32'h0},
            '{1'b0, LH_SH, 32'h27, 32'h0}, '{1'b0, LW_SW, 32'h26, 32'h0}};
    test_directed("split", ops);
  endtask
  task automatic test_latency_backpressure();
    logic [31:0] erd, d0;
    logic eflt;
    int elat, lat = 1, bad = 0, n = 0;
    op_t op;
    op = '{1'b0, LW_SW, 32'h20, 32'h0};
    model(op, erd, eflt, elat);
    while (req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = op.sz;
    req_addr = op.a;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      if (req_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != elat) $display("FAIL bp_latency: latency=%0d expected %0d", lat, elat);
    else passed++;
    d0 = rsp_rdata;
    total++;
    if (d0 !== erd || rsp_fault !== eflt)
      $display("FAIL bp_data: rdata=%h fault=%b expected %h %b", d0, rsp_fault, erd, eflt);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || req_ready !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold: %0d cycles unstable or ready, expected 0", bad);
    else passed++;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_release: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
    else passed++;
  endtask
  task automatic test_random();
    op_t ops[$];
    op_t op;
    int sel;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      op.we = $urandom_range(0, 2) == 0;
      op.sz = 3'($urandom_range(0, 7));
      op.a = sel < 6 ? 32'($urandom_range(0, 47)) : sel < 9 ? 32'(DEPTH - 6 + $urandom_range(0, 9)) : $urandom;
      op.wd = $urandom;
      ops.push_back(op);
    end
    test_directed("random", ops);
  endtask
  task automatic test_reset_mid_wait();
    int n = 0, seen = 0, cyc = 0, lat, elat;
    logic [31:0] rd, erd;
    logic flt, eflt;
    op_t op;
    while (req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = LW_SW;
    req_addr = 32'h20;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (rsp_valid === 1'b1) seen++;
    @(negedge clk);
    if (rsp_valid === 1'b1) seen++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (clr_busy !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL midwait_clear: clr_busy=%b req_ready=%b expected 1 0", clr_busy, req_ready);
    else passed++;
    while (clr_busy === 1'b1 && cyc < 5000) begin
      if (rsp_valid !== 1'b0) seen++;
      cyc++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) $display("FAIL midwait_rsp: rsp_valid seen %0d cycles, expected 0", seen);
    else passed++;
    total++;
    if (cyc != DEPTH / 4) $display("FAIL midwait_clear_len: %0d cycles, expected %0d", cyc, DEPTH / 4);
    else passed++;
    clear_model();
    op = '{1'b0, LW_SW, 32'h20, 32'h0};
    model(op, erd, eflt, elat);
    run(op, rd, flt, lat);
    total++;
    if (rd !== erd || flt !== eflt || lat != elat)
      $display("FAIL midwait_reload: rdata=%h fault=%b lat=%0d, expected %h %b %0d", rd, flt, lat, erd, eflt, elat);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_byte_lanes();
    test_latency_backpressure();
    test_faults();
    test_zero_ro();
    test_split();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
